// File: rtl/decoder_scan_nx_pkg.sv
// Shared FSM encoding and sizing helpers for the registered decoder/scanner.
package decoder_scan_nx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Dwell counter width: enough to hold DWELL, never narrower than one bit.
    function automatic int cnt_width(input int dwell);
        int w;
        w = $clog2(dwell + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder_scan_nx_onehot_dec.sv
// Combinational code to active-high one-hot decoder, shared by DECODE and SCAN paths.
// Latency 0 cycles; no flow control (pure function of code).
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      code,
    output logic [(2**SEL_W)-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered one-hot decoder with self-timed scan mode (DECODE on sel_vld, SCAN every DWELL cycles).
// Latency 1 cycle from sampled inputs to y/idx/wrap; no backpressure, every sel_vld is accepted.
module decoder_scan_nx
    import decoder_scan_nx_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  sel_vld,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = cnt_width(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [OUT_W-1:0] Y_IDLE   = ACTIVE_LOW ? '1 : '0;

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [SEL_W-1:0]  nxt_idx, idx_inc, dec_code;
    logic [OUT_W-1:0]  nxt_act, y_act, dec_oh;
    logic              nxt_wrap;

    assign idx_inc = idx + SEL_W'(1);
    assign y_act   = ACTIVE_LOW ? ~y : y;

    // Decoder input chosen separately from the next-state logic so the shared
    // decoder never sits inside a combinational feedback path.
    always_comb begin
        dec_code = '0;
        if (en && !mode)
            dec_code = sel_i;
        else if (en && mode && state == ST_SCAN)
            dec_code = idx_inc;
    end

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .code   (dec_code),
        .onehot (dec_oh)
    );

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        nxt_act   = y_act;
        nxt_wrap  = 1'b0;
        if (!en) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
            nxt_act   = '0;
        end else if (!mode) begin
            nxt_state = ST_DECODE;
            nxt_cnt   = '0;
            if (sel_vld) begin
                nxt_idx = sel_i;
                nxt_act = dec_oh;
            end else if (state != ST_DECODE) begin
                nxt_idx = '0;
                nxt_act = '0;
            end
        end else begin
            nxt_state = ST_SCAN;
            if (state != ST_SCAN) begin
                // Fresh scan: line 0 counts its entry cycle as the first dwell cycle.
                nxt_cnt = '0;
                nxt_idx = '0;
                nxt_act = {{(OUT_W-1){1'b0}}, 1'b1};
            end else if (cnt == CNT_LAST) begin
                nxt_cnt  = '0;
                nxt_idx  = idx_inc;
                nxt_act  = dec_oh;
                nxt_wrap = (idx_inc == '0);
            end else begin
                nxt_cnt = cnt + CNT_W'(1);
            end
        end
    end

    // Polarity applied on the register input so y leaves the flop directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            wrap  <= 1'b0;
            y     <= Y_IDLE;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            idx   <= nxt_idx;
            wrap  <= nxt_wrap;
            y     <= ACTIVE_LOW ? ~nxt_act : nxt_act;
        end
    end

endmodule
